avalon_key_debounce_pio: RTL and testbench

- Parametrised Avalon-MM input PIO for pushbuttons and switches. Successor to the fixed 4-bit edge-capture key port.
- Per-channel features: 2-flop synchroniser, programmable debounce, polarity inversion, selectable edge type (rising/falling/any), write-1-to-clear edge capture, masked level IRQ.
- Sits between the board key/switch pins and the system interconnect, next to the other PIO slaves.

---
 rtl/avalon_key_debounce_pio_pkg.sv | 33 +++
 rtl/avalon_key_debounce_pio_chan.sv | 55 +++++
 rtl/avalon_key_debounce_pio.sv | 98 +++++++++
 tb/tb_avalon_key_debounce_pio.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_key_debounce_pio_pkg.sv
// Shared definitions for the key/switch debounce PIO: register map and
// per-channel edge-mode encodings.
package avalon_key_debounce_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_RAW          = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_EDGE_MODE    = 3'd4;
  localparam logic [2:0] ADDR_PERIOD       = 3'd5;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_ANY  = 2'b11
  } edge_mode_e;

  // Qualify a stable-value toggle by the channel's edge mode.
  // level is the new stable value the channel is about to take.
  function automatic logic edge_qualify(edge_mode_e mode, logic toggle, logic level);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = toggle & level;
      EDGE_FALL: hit = toggle & ~level;
      EDGE_ANY:  hit = toggle;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/avalon_key_debounce_pio_chan.sv
// Single input channel: 2-flop synchroniser, optional inversion, debounce
// counter, stable flop and a qualified edge-event strobe.
module key_debounce_chan
  import avalon_key_debounce_pio_pkg::*;
#(
  parameter int   DB_BITS = 16,
  parameter logic INVERT  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_bit,
  input  logic [DB_BITS-1:0] period,
  input  edge_mode_e         mode,
  output logic               raw,
  output logic               stable,
  output logic               edge_event
);

  logic               s1;
  logic               s2;
  logic [DB_BITS-1:0] cnt;
  logic [DB_BITS-1:0] limit;
  logic               settle;

  assign raw = s2 ^ INVERT;

  // A period of 0 behaves like 1: the terminal count is then 0.
  assign limit  = (period == '0) ? '0 : period - DB_BITS'(1);
  assign settle = (raw != stable) && (cnt >= limit);

  // Event fires on the same edge that stable takes the new value.
  assign edge_event = edge_qualify(mode, settle, raw);

  // Synchroniser and debounce counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= in_bit;
      s2 <= s1;
      if (raw == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/avalon_key_debounce_pio.sv
// Avalon-MM input PIO for keys/switches: per-channel debounce, edge capture
// with write-1-to-clear, masked level interrupt, registered read data.
module avalon_key_debounce_pio
  import avalon_key_debounce_pio_pkg::*;
#(
  parameter int               WIDTH            = 4,
  parameter int               DB_BITS          = 16,
  parameter int               DEBOUNCE_DEFAULT = 50000,
  parameter logic [WIDTH-1:0] INVERT_MASK      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic                 wr;
  logic [WIDTH-1:0]     data;
  logic [WIDTH-1:0]     raw;
  logic [WIDTH-1:0]     evt;
  logic [WIDTH-1:0]     irq_mask;
  logic [WIDTH-1:0]     edge_capture;
  logic [WIDTH-1:0]     clear_bits;
  logic [2*WIDTH-1:0]   edge_mode;
  logic [DB_BITS-1:0]   period;
  logic [31:0]          rd_mux;
  logic                 unused_bits;

  assign wr          = chipselect & ~write_n;
  assign unused_bits = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    key_debounce_chan #(
      .DB_BITS (DB_BITS),
      .INVERT  (INVERT_MASK[i])
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .in_bit     (in_port[i]),
      .period     (period),
      .mode       (edge_mode_e'(edge_mode[2*i +: 2])),
      .raw        (raw[i]),
      .stable     (data[i]),
      .edge_event (evt[i])
    );
  end

  // New events are OR-ed in after the clear, so a same-cycle event survives.
  assign clear_bits = (wr && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  // Control registers and edge capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      edge_mode    <= '1;
      period       <= DB_BITS'(DEBOUNCE_DEFAULT);
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | evt;
      if (wr) begin
        case (address)
          ADDR_IRQ_MASK:  irq_mask  <= writedata[WIDTH-1:0];
          ADDR_EDGE_MODE: edge_mode <= writedata[2*WIDTH-1:0];
          ADDR_PERIOD:    period    <= writedata[DB_BITS-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read mux; unused bits and unmapped addresses read 0.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:         rd_mux[WIDTH-1:0]   = data;
      ADDR_RAW:          rd_mux[WIDTH-1:0]   = raw;
      ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0]   = irq_mask;
      ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0]   = edge_capture;
      ADDR_EDGE_MODE:    rd_mux[2*WIDTH-1:0] = edge_mode;
      ADDR_PERIOD:       rd_mux[DB_BITS-1:0] = period;
      default:           rd_mux = '0;
    endcase
  end

  // Registered read data, reloaded every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_avalon_key_debounce_pio.sv
// Scoreboard bench for avalon_key_debounce_pio: stimulus tasks push expected
// values; a monitor pops and compares one cycle later.
module tb_avalon_key_debounce_pio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  logic        rst_inv = 1'b1;
  logic [2:0]  address_inv = '0;
  logic [3:0]  in_port_inv = '0;
  logic [31:0] readdata_inv;
  logic        irq_inv;

  always #5 clk = ~clk;

  avalon_key_debounce_pio #(
    .WIDTH            (4),
    .DB_BITS          (16),
    .DEBOUNCE_DEFAULT (50000),
    .INVERT_MASK      (4'b0000)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  avalon_key_debounce_pio #(
    .WIDTH            (4),
    .DB_BITS          (16),
    .DEBOUNCE_DEFAULT (8),
    .INVERT_MASK      (4'b0001)
  ) dut_inv (
    .clk        (clk),
    .reset      (rst_inv),
    .address    (address_inv),
    .chipselect (1'b0),
    .write_n    (1'b1),
    .writedata  (32'd0),
    .in_port    (in_port_inv),
    .readdata   (readdata_inv),
    .irq        (irq_inv)
  );

  typedef enum int {SRC_RD, SRC_IRQ, SRC_INV, SRC_WIN} src_e;
  typedef struct {
    src_e        src;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  cur;
  logic chk_req  = 1'b0;
  logic chk_seen = 1'b0;
  logic win_clr  = 1'b0;
  logic done     = 1'b0;
  int   irq_win  = 0;
  int   checks   = 0;
  int   errors   = 0;
  logic [31:0] act;

  always @(posedge clk) chk_seen <= chk_req;

  // Counts irq-high cycles since the last window clear.
  always @(posedge clk) begin
    if (win_clr)  irq_win <= 0;
    else if (irq) irq_win <= irq_win + 1;
  end

  // Monitor: compare the oldest expectation against what the DUT presents.
  always @(negedge clk) begin
    if (chk_seen) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_underflow: got no entry required one");
      end else begin
        cur = sb_q.pop_front();
        case (cur.src)
          SRC_IRQ: act = {31'd0, irq};
          SRC_INV: act = readdata_inv;
          SRC_WIN: act = irq_win;
          default: act = readdata;
        endcase
        if (act !== cur.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got 0x%0h required 0x%0h", cur.name, act, cur.exp);
        end
      end
    end
    if (done) begin
      done = 1'b0;
      checks = checks + 1;
      if (sb_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input src_e s, input logic [2:0] a, input logic [31:0] e, input string n);
    sb_t ent;
    @(negedge clk);
    if (s == SRC_INV) address_inv = a;
    else              address     = a;
    ent.src  = s;
    ent.exp  = e;
    ent.name = n;
    sb_q.push_back(ent);
    chk_req = 1'b1;
    @(posedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    issue(SRC_RD, a, e, n);
  endtask

  task automatic chk_irq(input logic e, input string n);
    issue(SRC_IRQ, 3'd0, {31'd0, e}, n);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(3);
    @(negedge clk) rst = 1'b0;
    rd(3'd0, 32'h0, "rst_data");
    rd(3'd1, 32'h0, "rst_raw");
    rd(3'd2, 32'h0, "rst_mask");
    rd(3'd3, 32'h0, "rst_capture");
    rd(3'd4, 32'hFF, "rst_mode");
    rd(3'd5, 32'd50000, "rst_period");
    chk_irq(1'b0, "rst_irq");

    // Basic rising edge on ch1, period 4: capture and irq at T+6
    wr(3'd5, 32'd4);
    wr(3'd2, 32'hF);
    wr(3'd4, 32'hFF);
    drive(4'b0010);
    idle(3);
    chk_irq(1'b0, "irq_t5");
    chk_irq(1'b1, "irq_t6");
    rd(3'd0, 32'h2, "data_ch1");
    rd(3'd3, 32'h2, "cap_ch1");
    wr(3'd3, 32'h2);
    chk_irq(1'b0, "irq_cleared");
    rd(3'd3, 32'h0, "cap_cleared");

    // 3-cycle pulse rejected, 4-cycle pulse accepted
    @(negedge clk) win_clr = 1'b1;
    @(posedge clk) #1 win_clr = 1'b0;
    drive(4'b0110);
    idle(2);
    drive(4'b0010);
    idle(12);
    issue(SRC_WIN, 3'd0, 32'd0, "irq_window_short");
    rd(3'd0, 32'h2, "data_short");
    rd(3'd3, 32'h0, "cap_short");
    drive(4'b0110);
    idle(3);
    drive(4'b0010);
    idle(4);
    rd(3'd3, 32'h4, "cap_pulse4");
    rd(3'd0, 32'h2, "data_pulse4_fell");
    wr(3'd3, 32'h4);

    // Falling-only mode on ch0
    wr(3'd4, 32'hFE);
    drive(4'b0011);
    idle(10);
    rd(3'd3, 32'h0, "cap_fall_rise_ignored");
    drive(4'b0010);
    idle(10);
    rd(3'd3, 32'h1, "cap_fall");
    chk_irq(1'b1, "irq_fall");
    wr(3'd3, 32'h1);
    chk_irq(1'b0, "irq_fall_cleared");
    rd(3'd3, 32'h0, "cap_fall_cleared");

    // Clear racing a new event
    wr(3'd4, 32'hFF);
    drive(4'b0011);
    idle(10);
    drive(4'b0001);
    idle(10);
    rd(3'd3, 32'h3, "cap_both");
    drive(4'b0011);
    idle(4);
    wr(3'd3, 32'h1);
    rd(3'd3, 32'h2, "cap_clear_other");
    drive(4'b0001);
    idle(4);
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h2, "cap_event_wins");
    wr(3'd3, 32'h0);
    rd(3'd3, 32'h2, "cap_w0_noop");
    wr(3'd6, 32'hFFFF);
    rd(3'd6, 32'h0, "addr6_zero");
    rd(3'd2, 32'hF, "mask_kept");
    rd(3'd0, 32'h1, "data_final");

    // Inverted channel, reset mid-count
    @(negedge clk) rst_inv = 1'b0;
    idle(1);
    issue(SRC_INV, 3'd1, 32'h1, "inv_raw");
    idle(2);
    @(negedge clk) rst_inv = 1'b1;
    issue(SRC_INV, 3'd5, 32'h0, "inv_rd_in_reset");
    @(negedge clk) rst_inv = 1'b0;
    idle(6);
    issue(SRC_INV, 3'd0, 32'h0, "inv_data_e7");
    issue(SRC_INV, 3'd0, 32'h1, "inv_data_e8");
    issue(SRC_INV, 3'd3, 32'h1, "inv_cap");
    issue(SRC_INV, 3'd5, 32'd8, "inv_period");
    issue(SRC_INV, 3'd4, 32'hFF, "inv_mode");

    idle(3);
    done = 1'b1;
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
